// File: rtl/uart_pkg.sv
// Shared definitions for the multi-byte UART receiver.
//   core_state_t : byte-core states (line re-arm, start search, start check,
//                  data bits, stop bit)
//   asm_state_t  : word-assembler states
//   MAX_BYTES, DATA_BITS, WORD_W : word geometry
//   clamp_bytes  : maps the bytes_num request onto the legal 1..8 range
package uart_pkg;

    localparam int MAX_BYTES = 8;
    localparam int DATA_BITS = 8;
    localparam int WORD_W    = MAX_BYTES * DATA_BITS;

    typedef enum logic [2:0] {
        C_WAIT_IDLE,
        C_IDLE,
        C_START,
        C_DATA,
        C_STOP
    } core_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_RECV,
        A_DONE
    } asm_state_t;

    // 0 and anything above MAX_BYTES both mean a full-width word.
    function automatic logic [3:0] clamp_bytes(input logic [3:0] n);
        return (n == 4'd0 || n > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : n;
    endfunction

endpackage

// File: rtl/uart_rx_byte_core.sv
// Single-byte 8N1 receiver core.
//   clk, reset    : system clock, asynchronous active-high reset
//   speed         : clk cycles per bit, latched at each start edge
//   rx            : raw serial line (idle high)
//   byte_data     : last received byte (valid while byte_valid is high)
//   byte_valid    : one-cycle pulse, the cycle after a good stop bit
//   ferr          : one-cycle pulse, the cycle after a low stop bit
//   start_det     : combinational, falling edge seen while idle
//   false_start   : combinational, start bit found high at its mid-point
//   idle          : combinational, core waiting for a start edge
module uart_rx_byte_core
    import uart_pkg::*;
#(
    parameter int SPEED_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic               rx,
    output logic [7:0]         byte_data,
    output logic               byte_valid,
    output logic               ferr,
    output logic               start_det,
    output logic               false_start,
    output logic               idle
);

    logic               rx_p0, rx_p1, rx_d;
    logic               rx_s, fall, half_hit, bit_tick;
    core_state_t        state, state_nxt;
    logic [SPEED_W-1:0] spd, cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shreg;

    // Stage p0/p1: two-flop synchroniser; rx_d keeps the previous
    // synchronised sample for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_d  <= rx_p1;
        end
    end

    assign rx_s     = rx_p1;
    assign fall     = rx_d & ~rx_s;
    assign half_hit = (cnt == (spd >> 1));
    assign bit_tick = (cnt == spd - SPEED_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= C_WAIT_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            C_WAIT_IDLE: if (rx_s) state_nxt = C_IDLE;
            C_IDLE:      if (fall) state_nxt = C_START;
            C_START:     if (half_hit) state_nxt = rx_s ? C_IDLE : C_DATA;
            C_DATA:      if (bit_tick && bit_idx == 3'(DATA_BITS - 1)) state_nxt = C_STOP;
            // A low stop bit leaves the line in an unknown phase, so the
            // core waits for it to return high before hunting for a start.
            C_STOP:      if (bit_tick) state_nxt = rx_s ? C_IDLE : C_WAIT_IDLE;
            default:     state_nxt = C_WAIT_IDLE;
        endcase
    end

    always_comb begin
        start_det   = (state == C_IDLE) && fall;
        false_start = (state == C_START) && half_hit && rx_s;
        idle        = (state == C_IDLE);
    end

    // Bit timing counters and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            byte_valid <= 1'b0;
            ferr       <= 1'b0;
        end else begin
            byte_valid <= (state == C_STOP) && bit_tick && rx_s;
            ferr       <= (state == C_STOP) && bit_tick && !rx_s;
            case (state)
                C_START: cnt <= half_hit ? '0 : cnt + SPEED_W'(1);
                C_DATA: begin
                    cnt <= bit_tick ? '0 : cnt + SPEED_W'(1);
                    if (bit_tick) bit_idx <= bit_idx + 3'd1;
                end
                C_STOP:  cnt <= bit_tick ? '0 : cnt + SPEED_W'(1);
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

    // Data path: bit period captured at the start edge so a speed change
    // mid-byte is ignored; bits shift in LSB first.
    always_ff @(posedge clk) begin
        if (state == C_IDLE && fall)
            spd <= speed;
        if (state == C_DATA && bit_tick)
            shreg <= {rx_s, shreg[7:1]};
    end

    assign byte_data = shreg;

endmodule

// File: rtl/uart_nbytes_rx.sv
// Multi-byte UART receiver: collects 1..8 8N1 bytes into one 64-bit word.
//   clk, reset     : system clock, asynchronous active-high reset
//   speed          : clk cycles per bit period (16 .. 2^SPEED_W-1)
//   bytes_num      : bytes per word, 0 or >8 means 8
//   rx             : raw serial line (idle high)
//   bytes_recv     : assembled word, right-aligned, first byte most significant
//   data_valid     : one-cycle pulse when bytes_recv is updated
//   rx_busy_nbytes : high while a word is in progress
//   frame_err      : one-cycle pulse on a low stop bit (word discarded)
//   rx_timeout     : one-cycle pulse when the inter-byte gap is exceeded
module uart_nbytes_rx
    import uart_pkg::*;
#(
    parameter int TIMEOUT_BITS = 20,
    parameter int SPEED_W      = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic [3:0]         bytes_num,
    input  logic               rx,
    output logic [WORD_W-1:0]  bytes_recv,
    output logic               data_valid,
    output logic               rx_busy_nbytes,
    output logic               frame_err,
    output logic               rx_timeout
);

    localparam int GAP_W = SPEED_W + 5;

    function automatic logic [GAP_W-1:0] sat_inc(input logic [GAP_W-1:0] v);
        return (&v) ? v : v + GAP_W'(1);
    endfunction

    logic [7:0]         byte_data;
    logic               byte_valid, ferr, start_det, false_start, core_idle;
    asm_state_t         state, state_nxt;
    logic [3:0]         target, count;
    logic [WORD_W-1:0]  shreg, shreg_nxt;
    logic [SPEED_W-1:0] spd;
    logic [GAP_W-1:0]   gap, limit;
    logic               last_byte, tmo_hit;

    uart_rx_byte_core #(.SPEED_W(SPEED_W)) u_core (
        .clk         (clk),
        .reset       (reset),
        .speed       (speed),
        .rx          (rx),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .ferr        (ferr),
        .start_det   (start_det),
        .false_start (false_start),
        .idle        (core_idle)
    );

    assign shreg_nxt = {shreg[WORD_W-DATA_BITS-1:0], byte_data};
    assign last_byte = byte_valid && (count + 4'd1 == target);
    assign limit     = GAP_W'(TIMEOUT_BITS) * GAP_W'(spd);
    // A start edge on the expiry cycle takes priority over the timeout.
    assign tmo_hit   = core_idle && !start_det && (gap >= limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= A_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            A_IDLE: if (start_det) state_nxt = A_RECV;
            A_RECV: begin
                if (ferr)                             state_nxt = A_IDLE;
                else if (last_byte)                   state_nxt = A_DONE;
                else if (false_start && count == 4'd0) state_nxt = A_IDLE;
                else if (tmo_hit)                     state_nxt = A_IDLE;
            end
            A_DONE:  state_nxt = start_det ? A_RECV : A_IDLE;
            default: state_nxt = A_IDLE;
        endcase
    end

    always_comb begin
        data_valid     = (state == A_DONE);
        rx_busy_nbytes = (state != A_IDLE);
        frame_err      = ferr;
        rx_timeout     = (state == A_RECV) && tmo_hit && !ferr && !byte_valid;
    end

    // Control: word target, byte count, gap counter and the output word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target     <= 4'(MAX_BYTES);
            count      <= '0;
            gap        <= '0;
            bytes_recv <= '0;
        end else begin
            if (state != A_RECV && start_det) begin
                target <= clamp_bytes(bytes_num);
                count  <= '0;
            end else if (state == A_RECV && byte_valid) begin
                count <= count + 4'd1;
                if (last_byte && !ferr)
                    bytes_recv <= shreg_nxt;
            end
            if (state != A_RECV || start_det)
                gap <= '0;
            else if (core_idle)
                gap <= sat_inc(gap);
        end
    end

    // Data: word shift register and the bit period used for the timeout.
    always_ff @(posedge clk) begin
        if (start_det)
            spd <= speed;
        if (state != A_RECV && start_det)
            shreg <= '0;
        else if (state == A_RECV && byte_valid)
            shreg <= shreg_nxt;
    end

endmodule
